// File: rtl/softmax_pkg.sv
// Shared softmax types and constants: lane count, FP16 -inf, packer
// states and row-length decode.
package softmax_pkg;

  localparam int N_DEF = 64;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } pk_state_t;

  // Row length L = 4*(mode+1), giving 4..64.
  function automatic logic [6:0] len_decode(input logic [3:0] mode);
    return ({3'b000, mode} + 7'd1) << 2;
  endfunction

endpackage

// File: rtl/softmax_row_packer.sv
// Packs FP16 scalars into one N-lane row, padding unused lanes.
// Define ROW_PACKER_LAST_EN to add the s_last early-termination port.
module softmax_row_packer
  import softmax_pkg::*;
#(
  parameter int          N         = N_DEF,
  parameter logic [15:0] PAD_VALUE = FP16_NEG_INF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      i_length_mode,
  input  logic [15:0]     s_data,
  input  logic            s_valid,
  output logic            s_ready,
`ifdef ROW_PACKER_LAST_EN
  input  logic            s_last,
`endif
  input  logic            next_ready,
  output logic            x_out_valid,
  output logic [N*16-1:0] x_out,
  output logic [6:0]      o_row_len
);

  pk_state_t  state;
  logic [6:0] cnt;
  logic [6:0] len_q;
  logic [6:0] cur_len;
  logic       xfer;
  logic       row_end;

  assign s_ready = (state == FILL);
  assign xfer    = s_valid & s_ready;

  // First scalar of a row uses the live mode; later ones the latched one.
  assign cur_len = (cnt == 7'd0) ? len_decode(i_length_mode) : len_q;

`ifdef ROW_PACKER_LAST_EN
  assign row_end = xfer & ((cnt + 7'd1 == cur_len) | s_last);
`else
  assign row_end = xfer & (cnt + 7'd1 == cur_len);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      len_q       <= 7'd64;
      x_out_valid <= 1'b0;
      x_out       <= '0;
      o_row_len   <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (xfer) begin
            if (cnt == 7'd0) len_q <= cur_len;
            for (int k = 0; k < N; k++) begin
              if (7'(k) == cnt)
                x_out[k*16 +: 16] <= s_data;
              else if (row_end && 7'(k) > cnt)
                x_out[k*16 +: 16] <= PAD_VALUE;
            end
            if (row_end) begin
              state       <= SEND;
              x_out_valid <= 1'b1;
              o_row_len   <= cnt + 7'd1;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        SEND: begin
          if (next_ready) begin
            state       <= FILL;
            x_out_valid <= 1'b0;
            cnt         <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_packer.sv
// Scoreboard bench for softmax_row_packer.
// Early-termination case runs only when ROW_PACKER_LAST_EN is defined.
module tb_softmax_row_packer;

  localparam int N = 64;
  localparam logic [15:0] PAD = 16'hFC00;

  typedef struct {
    string          name;
    logic [N*16-1:0] data;
    logic [6:0]     len;
  } row_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      i_length_mode = 4'd0;
  logic [15:0]     s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            s_last_r = 1'b0;
  logic            next_ready = 1'b1;
  logic            x_out_valid;
  logic [N*16-1:0] x_out;
  logic [6:0]      o_row_len;

  int checks = 0;
  int errors = 0;
  int rows_out = 0;
  int cyc = 0;
  int last_xfer = 0;
  int prev_xfer = 0;
  row_t sb[$];
  logic [15:0] vals[64];

  softmax_row_packer #(.N(N), .PAD_VALUE(PAD)) dut (
    .clk(clk),
    .rst(rst),
    .i_length_mode(i_length_mode),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
`ifdef ROW_PACKER_LAST_EN
    .s_last(s_last_r),
`endif
    .next_ready(next_ready),
    .x_out_valid(x_out_valid),
    .x_out(x_out),
    .o_row_len(o_row_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*16-1:0] build_row(input logic [15:0] v[64],
                                                 input int len);
    logic [N*16-1:0] r;
    for (int k = 0; k < N; k++)
      r[k*16 +: 16] = (k < len) ? v[k] : PAD;
    return r;
  endfunction

  // Row leaves on the next posedge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && x_out_valid && next_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_row", 64'd1, 64'd0);
      end else begin
        row_t e;
        e = sb.pop_front();
        check({e.name, "_len"}, 64'(o_row_len), 64'(e.len));
        for (int k = 0; k < N; k++)
          check($sformatf("%s_lane%0d", e.name, k),
                64'(x_out[k*16 +: 16]), 64'(e.data[k*16 +: 16]));
      end
      rows_out++;
      prev_xfer = last_xfer;
      last_xfer = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scalar(input logic [15:0] d);
    int t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("s_ready_timeout", 64'd0, 64'd1);
    tick();
    s_valid  = 1'b0;
    s_last_r = 1'b0;
  endtask

  task automatic send_row(input string name, input int mode, input int len,
                          input int alt_at, input int alt_mode,
                          input int last_at);
    row_t e;
    e.name = name;
    e.len  = 7'(len);
    e.data = build_row(vals, len);
    i_length_mode = 4'(mode);
    for (int k = 0; k < len; k++) begin
      if (k == alt_at) i_length_mode = 4'(alt_mode);
      if (k == len - 1) sb.push_back(e);
      s_last_r = (k == last_at);
      push_scalar(vals[k]);
      if (k < len - 1)
        check({name, "_not_done"}, 64'(x_out_valid), 64'd0);
      else
        check({name, "_valid_lat"}, 64'(x_out_valid), 64'd1);
    end
  endtask

  initial begin
    int rb;
    int t;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_valid", 64'(x_out_valid), 64'd0);
    check("rst_len", 64'(o_row_len), 64'd0);
    check("rst_xout_lo", x_out[63:0], 64'd0);
    check("rst_xout_hi", x_out[N*16-1 -: 64], 64'd0);

    // Short row, mostly padding.
    vals[0] = 16'h3C00; vals[1] = 16'h4000;
    vals[2] = 16'h4200; vals[3] = 16'h4400;
    send_row("m0", 0, 4, -1, 0, -1);
    tick();
    check("m0_sready_after", 64'(s_ready), 64'd1);

    // Full row, no padding.
    for (int k = 0; k < 64; k++) vals[k] = 16'h3C00 + 16'(k);
    send_row("m15", 15, 64, -1, 0, -1);
    tick();
    check("m15_sready_next", 64'(s_ready), 64'd1);
    check("m15_valid_drop", 64'(x_out_valid), 64'd0);

    // Backpressure hold.
    for (int k = 0; k < 64; k++) vals[k] = 16'h5000 + 16'(k * 3);
    next_ready = 1'b0;
    send_row("bp", 1, 8, -1, 0, -1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(x_out_valid), 64'd1);
      check("bp_sready", 64'(s_ready), 64'd0);
      check("bp_len", 64'(o_row_len), 64'd8);
      check("bp_lane7", 64'(x_out[7*16 +: 16]), 64'(vals[7]));
      check("bp_lane8", 64'(x_out[8*16 +: 16]), 64'(PAD));
    end
    rb = rows_out;
    next_ready = 1'b1;
    tick();
    check("bp_valid_off", 64'(x_out_valid), 64'd0);
    repeat (3) tick();
    check("bp_one_xfer", 64'(rows_out), 64'(rb + 1));

    // Mode change mid-row is ignored.
    for (int k = 0; k < 64; k++) vals[k] = 16'h4800 ^ 16'(k * 17);
    send_row("mchg", 1, 8, 3, 0, -1);

    // Reset mid-row discards partial data.
    i_length_mode = 4'd1;
    for (int k = 0; k < 5; k++) push_scalar(16'h7000 + 16'(k));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 64'(x_out_valid), 64'd0);
    check("mid_rst_xout", x_out[63:0], 64'd0);
    check("mid_rst_xout4", 64'(x_out[4*16 +: 16]), 64'd0);
    check("mid_rst_len", 64'(o_row_len), 64'd0);
    for (int k = 0; k < 64; k++) vals[k] = 16'h2000 + 16'(k * 5);
    send_row("post_rst", 1, 8, -1, 0, -1);

    // Back-to-back rows give an L+1 cycle period.
    for (int k = 0; k < 64; k++) vals[k] = 16'(k * 257);
    send_row("b2b_a", 0, 4, -1, 0, -1);
    send_row("b2b_b", 0, 4, -1, 0, -1);
    tick();
    check("b2b_period", 64'(last_xfer - prev_xfer), 64'd5);

`ifdef ROW_PACKER_LAST_EN
    for (int k = 0; k < 64; k++) vals[k] = 16'h3800 + 16'(k);
    send_row("last3", 15, 3, -1, 0, 2);
`endif

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
